// File: rtl/fifo_burst_scheduler_pkg.sv
// Shared types and helpers for the FIFO burst scheduler.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package fifo_burst_scheduler_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // Clamp the requested burst length into 1..depth; a request of 0 means single beats.
   function automatic int unsigned effective_size(input int unsigned size, input int unsigned depth);
      if (size == 0) begin
         return 1;
      end else if (size > depth) begin
         return depth;
      end else begin
         return size;
      end
   endfunction

endpackage

// File: rtl/fifo_burst_scheduler_if.sv
// Bundle of FIFO read-port, control and output stream signals for the burst scheduler.
// Latency: none (wiring only).
// Backpressure: out_ready from the consumer, carried through to the scheduler.
interface fifo_burst_scheduler_if #(
   parameter int WIDTH         = 8,
   parameter int DEPTH_LOG2    = 2,
   parameter int TIMEOUT_WIDTH = 8
);
   logic [DEPTH_LOG2:0]    burst_size;
   logic [TIMEOUT_WIDTH-1:0] timeout_cycles;
   logic [DEPTH_LOG2:0]    fifo_level;
   logic                   fifo_empty;
   logic                   fifo_read_enable;
   logic [WIDTH-1:0]       fifo_read_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic                   out_first;
   logic                   out_last;
   logic [DEPTH_LOG2:0]    burst_length;
   logic                   busy;
   logic                   burst_error;

   // Scheduler side.
   modport master (
      input  burst_size, timeout_cycles, fifo_level, fifo_empty, fifo_read_data, out_ready,
      output fifo_read_enable, out_valid, out_data, out_first, out_last,
             burst_length, busy, burst_error
   );

   // Environment side: FIFO, configuration and consumer.
   modport slave (
      output burst_size, timeout_cycles, fifo_level, fifo_empty, fifo_read_data, out_ready,
      input  fifo_read_enable, out_valid, out_data, out_first, out_last,
             burst_length, busy, burst_error
   );
endinterface

// File: rtl/fifo_burst_output_stage.sv
// One-entry valid/ready output register carrying data plus first/last markers.
// Latency: 1 cycle from load to valid.
// Backpressure: holds contents while valid && !ready; free = empty or draining this cycle.
module fifo_burst_output_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             load,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_first,
   input  logic             in_last,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             first,
   output logic             last,
   output logic             free
);

   assign free = !valid || ready;

   // Capture a popped beat, or retire the held beat once the consumer takes it.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         valid <= 1'b0;
         data  <= '0;
         first <= 1'b0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= in_data;
         first <= in_first;
         last  <= in_last;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_burst_scheduler.sv
// Reads a FIFO in bursts of clamped length onto a registered valid/ready stream with first/last
// markers; optional idle timeout flushes partial bursts (FIFO_BURST_SCHEDULER_TIMEOUT_EN).
// Latency: level seen -> first pop next cycle -> beat valid the cycle after; backpressure stalls pops.
module fifo_burst_scheduler
   import fifo_burst_scheduler_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 4,
   parameter int DEPTH_LOG2    = $clog2(DEPTH),
   parameter int TIMEOUT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   resetn,
   fifo_burst_scheduler_if.master bus
);

   localparam int LEN_W = DEPTH_LOG2 + 1;
   typedef logic [LEN_W-1:0] len_t;

   state_t state;
   len_t   remaining;
   len_t   eff_size;
   len_t   start_len;
   logic   start_full;
   logic   start_timeout;
   logic   burst_start;
   logic   stage_free;
   logic   pop;
   logic   truncate;

   assign eff_size    = len_t'(effective_size(32'(bus.burst_size), DEPTH));
   assign start_full  = (state == IDLE) && (bus.fifo_level >= eff_size);
   assign burst_start = start_full || start_timeout;
   assign start_len   = start_full ? eff_size : bus.fifo_level;

`ifdef FIFO_BURST_SCHEDULER_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0] timeout_count;
   logic [TIMEOUT_WIDTH:0]   count_next;

   assign count_next    = {1'b0, timeout_count} + (TIMEOUT_WIDTH + 1)'(1);
   // A zero level with a non-empty flag would launch an empty burst, so require real data.
   assign start_timeout = (state == IDLE) && !start_full && !bus.fifo_empty &&
                          (bus.fifo_level != '0) && (bus.timeout_cycles != '0) &&
                          (count_next == {1'b0, bus.timeout_cycles});

   // Count idle cycles spent holding a partial burst; saturate rather than wrap.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         timeout_count <= '0;
      end else if (state != IDLE || bus.fifo_empty || burst_start) begin
         timeout_count <= '0;
      end else if (bus.fifo_level < eff_size && timeout_count != '1) begin
         timeout_count <= timeout_count + TIMEOUT_WIDTH'(1);
      end
   end
`else
   assign start_timeout = 1'b0;
`endif

   // No pop while held in reset, so the FIFO never loses a word to a beat that gets dropped.
   assign pop      = resetn && (state == BURST) && (remaining != '0) &&
                     !bus.fifo_empty && stage_free;
   assign truncate = (state == BURST) && (remaining != '0) && bus.fifo_empty;

   assign bus.fifo_read_enable = pop;

   // Burst sequencing: launch on level or timeout, count pops down, abort on an emptied FIFO.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state            <= IDLE;
         remaining        <= '0;
         bus.burst_length <= '0;
         bus.busy         <= 1'b0;
         bus.burst_error  <= 1'b0;
      end else begin
         bus.burst_error <= 1'b0;
         case (state)
            IDLE: begin
               if (burst_start) begin
                  state            <= BURST;
                  remaining        <= start_len;
                  bus.burst_length <= start_len;
                  bus.busy         <= 1'b1;
               end
            end
            BURST: begin
               if (pop) begin
                  remaining <= remaining - len_t'(1);
                  if (remaining == len_t'(1)) begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end
               end else if (truncate) begin
                  state           <= IDLE;
                  remaining       <= '0;
                  bus.busy        <= 1'b0;
                  bus.burst_error <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

   // The first pop is the one made while nothing has been taken yet from the registered length.
   fifo_burst_output_stage #(
      .WIDTH (WIDTH)
   ) u_output_stage (
      .clock    (clock),
      .resetn   (resetn),
      .load     (pop),
      .in_data  (bus.fifo_read_data),
      .in_first (remaining == bus.burst_length),
      .in_last  (remaining == len_t'(1)),
      .ready    (bus.out_ready),
      .valid    (bus.out_valid),
      .data     (bus.out_data),
      .first    (bus.out_first),
      .last     (bus.out_last),
      .free     (stage_free)
   );

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// Bench for fifo_burst_scheduler: queue-based FIFO, cycle reference model, directed and random stimulus.
// Latency: checks every cycle on the falling edge.
// Backpressure: out_ready driven per test pattern or randomly.
module tb_fifo_burst_scheduler;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int DEPTH_LOG2 = 2;
   localparam int TW = 8;
   localparam int LEN_W = DEPTH_LOG2 + 1;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   fifo_burst_scheduler_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .TIMEOUT_WIDTH(TW)) bus ();

   fifo_burst_scheduler #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2), .TIMEOUT_WIDTH(TW)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // ---------------- FIFO model driven from a queue ----------------
   logic [WIDTH-1:0] fq[$];

   task automatic drive_fifo();
      bus.fifo_level     = LEN_W'(fq.size());
      bus.fifo_empty     = (fq.size() == 0);
      bus.fifo_read_data = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      if (fq.size() < DEPTH) fq.push_back(w);
      drive_fifo();
   endtask

   // ---------------- behavioural reference ----------------
   bit m_burst, m_ov, m_of, m_ol, m_err;
   int m_rem, m_len, m_done, m_cnt;
   logic [WIDTH-1:0] m_od;
   bit re_s;
   int cyc_n = 0;
   int pop_cnt = 0;

   function automatic int clamp_s(input int bs);
      if (bs == 0) return 1;
      if (bs > DEPTH) return DEPTH;
      return bs;
   endfunction

   function automatic bit m_pop();
      return (resetn === 1'b1) && m_burst && (m_rem > 0) && !bus.fifo_empty &&
             (!m_ov || bus.out_ready);
   endfunction

   always @(posedge clock) begin
      bit p;
      bit start;
      int s;
      int slen;
      p = m_pop();
      s = clamp_s(int'(bus.burst_size));
      if (resetn !== 1'b1) begin
         m_burst = 0; m_ov = 0; m_of = 0; m_ol = 0; m_err = 0; m_od = '0;
         m_rem = 0; m_len = 0; m_done = 0; m_cnt = 0;
      end else begin
         m_err = 0;
         if (p) begin
            m_ov = 1; m_od = bus.fifo_read_data; m_of = (m_done == 0); m_ol = (m_rem == 1);
         end else if (m_ov && bus.out_ready) begin
            m_ov = 0;
         end
         if (!m_burst) begin
            start = 0;
            slen = 0;
            if (int'(bus.fifo_level) >= s) begin
               start = 1; slen = s;
            end
`ifdef FIFO_BURST_SCHEDULER_TIMEOUT_EN
            else if (bus.timeout_cycles != 0 && !bus.fifo_empty &&
                     m_cnt + 1 == int'(bus.timeout_cycles)) begin
               start = 1; slen = int'(bus.fifo_level);
            end
            if (start || bus.fifo_empty) m_cnt = 0;
            else if (int'(bus.fifo_level) < s && m_cnt < 255) m_cnt++;
`endif
            if (start) begin
               m_burst = 1; m_rem = slen; m_len = slen; m_done = 0;
            end
         end else begin
            m_cnt = 0;
            if (p) begin
               m_rem--; m_done++;
               if (m_rem == 0) m_burst = 0;
            end else if (bus.fifo_empty) begin
               m_burst = 0; m_rem = 0; m_err = 1;
            end
         end
      end
      if (re_s) begin
         if (fq.size() > 0) void'(fq.pop_front());
         pop_cnt++;
      end
      cyc_n++;
   end

   // ---------------- per-cycle compare and beat log ----------------
   bit run_chk = 0;
   logic [WIDTH-1:0] lg_d[$];
   bit lg_f[$];
   bit lg_l[$];
   int re_cnt, re_run, re_run_max, first_re, first_ov, err_cnt, last_len;

   task automatic clear_log();
      lg_d.delete(); lg_f.delete(); lg_l.delete();
      re_cnt = 0; re_run = 0; re_run_max = 0; first_re = -1; first_ov = -1;
      err_cnt = 0; last_len = -1;
   endtask

   always @(negedge clock) begin
      re_s = (bus.fifo_read_enable === 1'b1);
      if (run_chk) begin
         check("read_enable", bus.fifo_read_enable, m_pop());
         check("out_valid", bus.out_valid, m_ov);
         if (m_ov) begin
            check("out_data", bus.out_data, m_od);
            check("out_first", bus.out_first, m_of);
            check("out_last", bus.out_last, m_ol);
         end
         check("busy", bus.busy, m_burst);
         check("burst_error", bus.burst_error, m_err);
         check("burst_length", bus.burst_length, m_len);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         lg_d.push_back(bus.out_data);
         lg_f.push_back(bus.out_first);
         lg_l.push_back(bus.out_last);
      end
      if (re_s) begin
         re_cnt++; re_run++;
         if (re_run > re_run_max) re_run_max = re_run;
         if (first_re < 0) first_re = cyc_n;
      end else begin
         re_run = 0;
      end
      if (bus.out_valid === 1'b1 && first_ov < 0) first_ov = cyc_n;
      if (bus.burst_error === 1'b1) err_cnt++;
      if (bus.busy === 1'b1) last_len = int'(bus.burst_length);
   end

   task automatic cyc();
      @(posedge clock);
      #1;
      drive_fifo();
   endtask

   task automatic expect_burst(input string tag, input int n, input logic [WIDTH-1:0] base,
                               input bit has_last);
      check({tag, "_count"}, lg_d.size(), n);
      for (int i = 0; i < n && i < lg_d.size(); i++) begin
         check({tag, "_data"}, lg_d[i], base + WIDTH'(i));
         check({tag, "_first"}, lg_f[i], (i == 0));
         check({tag, "_last"}, lg_l[i], (has_last && i == n - 1));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int base_pops;
      int push_cyc;
      bit rp[7];
      rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      bus.out_ready = 1'b1;
      bus.burst_size = 3'd4;
      bus.timeout_cycles = '0;
      resetn = 1'b0;
      drive_fifo();
      clear_log();
      cyc();
      run_chk = 1;
      cyc();
      // reset values
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_first", bus.out_first, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_burst_length", bus.burst_length, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_burst_error", bus.burst_error, 0);
      check("rst_read_enable", bus.fifo_read_enable, 0);
      resetn = 1'b1;

      // full burst of four with ready held high
      clear_log();
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      push_cyc = cyc_n;
      repeat (10) cyc();
      expect_burst("t1", 4, 8'hA0, 1);
      check("t1_re_count", re_cnt, 4);
      check("t1_re_consecutive", re_run_max, 4);
      check("t1_first_pop_delay", first_re - push_cyc, 1);
      check("t1_first_valid_delay", first_ov - push_cyc, 2);
      check("t1_burst_length", last_len, 4);

      // toggling ready
      clear_log();
      for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
      for (int i = 0; i < 7; i++) begin
         bus.out_ready = rp[i];
         cyc();
      end
      bus.out_ready = 1'b1;
      repeat (8) cyc();
      expect_burst("t2", 4, 8'hB0, 1);
      check("t2_re_count", re_cnt, 4);

      // partial burst: timeout flush, or waiting for the level without it
      clear_log();
      bus.timeout_cycles = 8'd5;
      push(8'hD0);
      push(8'hD1);
      push_cyc = cyc_n;
`ifdef FIFO_BURST_SCHEDULER_TIMEOUT_EN
      repeat (12) cyc();
      check("t3_timeout_start", first_re - push_cyc, 5);
      check("t3_burst_length", last_len, 2);
      expect_burst("t3", 2, 8'hD0, 1);
`else
      repeat (20) cyc();
      check("t3_no_partial_pop", re_cnt, 0);
      push(8'hD2);
      push(8'hD3);
      repeat (8) cyc();
      expect_burst("t3", 4, 8'hD0, 1);
`endif
      bus.timeout_cycles = '0;

      // burst_size 0 -> single-beat bursts
      clear_log();
      bus.burst_size = 3'd0;
      for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i));
      repeat (10) cyc();
      check("t4_count", lg_d.size(), 3);
      for (int i = 0; i < 3 && i < lg_d.size(); i++) begin
         check("t4_data", lg_d[i], 8'hE0 + 8'(i));
         check("t4_first", lg_f[i], 1);
         check("t4_last", lg_l[i], 1);
      end
      check("t4_burst_length", last_len, 1);

      // burst_size above depth clamps to depth
      clear_log();
      bus.burst_size = 3'd7;
      for (int i = 0; i < 4; i++) push(8'hF0 + 8'(i));
      repeat (8) cyc();
      expect_burst("t4b", 4, 8'hF0, 1);
      check("t4b_burst_length", last_len, 4);

      // truncation by flushing the FIFO after the second pop
      clear_log();
      bus.burst_size = 3'd4;
      for (int i = 0; i < 4; i++) push(8'h90 + 8'(i));
      base_pops = pop_cnt;
      for (int i = 0; i < 20 && (pop_cnt - base_pops) < 2; i++) cyc();
      fq.delete();
      drive_fifo();
      repeat (6) cyc();
      check("t5_pops", re_cnt, 2);
      check("t5_error_cycles", err_cnt, 1);
      check("t5_busy", bus.busy, 0);
      expect_burst("t5", 2, 8'h90, 0);

      // reset mid-burst with a beat held in the output register
      clear_log();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
      cyc();
      cyc();
      check("t6_held_valid", bus.out_valid, 1);
      resetn = 1'b0;
      cyc();
      check("t6_valid_after_reset", bus.out_valid, 0);
      check("t6_busy_after_reset", bus.busy, 0);
      resetn = 1'b1;
      bus.out_ready = 1'b1;
      push(8'hC4);
      repeat (8) cyc();
      expect_burst("t6", 4, 8'hC1, 1);

      // randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 40) push(8'($urandom));
         bus.out_ready = ($urandom_range(0, 99) < 70);
         if (!m_burst && $urandom_range(0, 19) == 0) bus.burst_size = 3'($urandom_range(0, 7));
`ifdef FIFO_BURST_SCHEDULER_TIMEOUT_EN
         if ($urandom_range(0, 49) == 0) bus.timeout_cycles = 8'($urandom_range(0, 12));
`endif
         if ($urandom_range(0, 299) == 0) fq.delete();
         resetn = ($urandom_range(0, 499) != 0);
         drive_fifo();
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_burst_scheduler.md
# fifo_burst_scheduler

Read-side controller for the synchronous advanced FIFO controller. It watches the FIFO level and empty flag. It issues reads in bursts of a programmable length onto a registered valid/ready stream carrying first/last markers, and it flushes partial bursts after an idle timeout. It sits between the FIFO read port and a burst-oriented consumer such as a bus master or DMA write channel, and it is the only reader of that FIFO.

## Interface
- WIDTH, 8, data width; must match the FIFO.
- DEPTH, 4, FIFO depth.
- DEPTH_LOG2, `CLOG2(DEPTH), FIFO address width; level, burst size and length ports are DEPTH_LOG2+1 bits wide.
- TIMEOUT_WIDTH, 8, width of the timeout counter and threshold.

Ports:
- clock  in  1  single clock for all logic.
- resetn  in  1  synchronous, active-low reset, sampled on the rising clock edge.
- burst_size  in  DEPTH_LOG2+1  requested burst length, held stable while not idle.
- timeout_cycles  in  TIMEOUT_WIDTH  partial-burst timeout; 0 disables it.
- fifo_level  in  DEPTH_LOG2+1  FIFO level.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_enable  out  1  pop strobe to the FIFO.
- fifo_read_data  in  WIDTH  FIFO head data, valid whenever fifo_empty is low.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  WIDTH  beat data.
- out_first  out  1  first beat of a burst.
- out_last  out  1  last beat of a burst.
- burst_length  out  DEPTH_LOG2+1  length of the current burst, registered at burst start.
- busy  out  1  high while state is BURST.
- burst_error  out  1  one-cycle pulse when a burst is truncated.

## Operation
- Effective size S:
  - burst_size of 0 gives S = 1.
  - burst_size greater than DEPTH gives S = DEPTH.
  - Otherwise S = burst_size.
- State IDLE:
  - If fifo_level >= S, go to BURST with remaining = S.
  - Otherwise, if the timeout fires, go to BURST with remaining = fifo_level.
- State BURST:
  - Pop when remaining > 0, the FIFO is not empty, and the output register is free (empty, or out_valid and out_ready both high this cycle).
  - Each pop decrements remaining.
  - The popped beat carries out_first if it is the first pop of the burst, and out_last if remaining = 1.
  - After the pop with remaining = 1, go to IDLE.
- Truncation: fifo_empty is high in BURST with remaining > 0, for example after an external FIFO flush.
  - Go to IDLE and pulse burst_error.
  - Beats already popped still drain normally. A truncated burst delivers no out_last.
- Output register:
  - One entry.
  - out_valid holds until out_ready is sampled high, and data/first/last stay stable while out_valid is high and out_ready is low.
- Reset values: state IDLE, out_valid 0, out_first 0, out_last 0, out_data 0, burst_length 0, busy 0, burst_error 0, fifo_read_enable 0, timeout count 0.

## Timing
- Full-size start: level condition seen in IDLE at cycle N; BURST and first pop at N+1; first out_valid at N+2.
- Pop-to-output latency is 1 cycle.
- Throughput is 1 beat per cycle while out_ready is held high; a burst of S beats occupies S output cycles.
- Back-pressure: when out_ready is low with the register full, there is no pop, and pops resume in the same cycle out_ready returns high.
- Back-to-back bursts: IDLE evaluates in the cycle after the final pop, so the next first pop may coincide with handshake of the previous out_last.
- Synchronous reset mid-burst: all state returns to reset values at the next edge, and any in-flight beat is dropped.

## Configuration
- `FIFO_BURST_SCHEDULER_TIMEOUT_EN` defined:
  - The counter increments each cycle in IDLE while fifo_empty is low and the level is below S, saturating at its maximum.
  - It clears when the FIFO is empty or a burst starts.
  - The timeout fires when timeout_cycles != 0 and count + 1 == timeout_cycles.
- Macro undefined:
  - No counter is built, timeout_cycles is ignored, and bursts start only on the level condition.
  - Partial data waits until the level reaches S.

## Structure
- Shared package fifo_burst_scheduler_pkg holds:
  - State enum {IDLE, BURST}.
  - Effective-size clamp function.
- Sub-module fifo_burst_output_stage is the one-entry valid/ready register carrying data, first and last.
  - Its free output feeds pop qualification.

## Test plan
- DEPTH=4, burst_size=4, push 4 words A..D, out_ready=1:
  - fifo_read_enable high for 4 consecutive cycles.
  - Beats A(first), B, C, D(last).
  - burst_length=4.
- Push 4 words with out_ready toggling 1,0,0,1,1,0,1:
  - Beats emitted in order with no loss or duplication.
  - Stable data while stalled.
  - No pop while the register is full and not ready.
- With `FIFO_BURST_SCHEDULER_TIMEOUT_EN`, timeout_cycles=5, burst_size=4, push 2 words:
  - Burst of length 2 starts 5 cycles after the level becomes non-zero.
  - out_last on the second beat.
- Burst_size=0:
  - Every word becomes a 1-beat burst with both first and last set.
  - Burst_size=7 on DEPTH=4 behaves as 4.
- Force fifo_empty high after the 2nd pop of a 4-beat burst:
  - One-cycle burst_error, return to IDLE.
  - 2 beats delivered, no out_last.
- Assert resetn=0 for 1 cycle mid-burst with out_valid high:
  - Next cycle: out_valid=0, busy=0, IDLE.
  - A new burst runs normally afterwards.
